// File: rtl/decode_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl
//
// Decode-stage controller for the pipelined core. It classifies the D-stage
// instruction by opcode, tells the sign-extension unit which immediate format
// to build, and loads the returned immediate together with the decoded
// control bits into the D/E pipeline register. It also detects load-use
// hazards (stalling F/D for one cycle and injecting a bubble into E), honours
// an E-stage flush, and keeps a saturating count of stall cycles.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   instr_d       in   D-stage instruction
//   valid_d       in   instr_d holds a real instruction
//   ext_imm_d     in   extended immediate returned by the sign-extension unit
//   flush_e       in   kill the instruction entering E (taken branch/jump)
//   imm_src_d     out  immediate format select (combinational from instr_d)
//   stall_fd      out  hold the F and D registers this cycle (combinational)
//   valid_e       out  E-stage instruction valid
//   imm_e         out  registered immediate
//   rd_e/rs1_e/rs2_e out registered register indices
//   reg_write_e, mem_read_e, mem_write_e, alu_src_e, alu_a_pc_e
//                 out  registered controls
//   result_src_e  out  00 ALU, 01 memory, 10 PC+4, 11 immediate
//   illegal_e     out  unknown opcode in E
//   stall_count   out  saturating count of stall cycles
// ---------------------------------------------------------------------------
module decode_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMM_WIDTH      = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     instr_d,
    input  logic                      valid_d,
    input  logic [DATA_WIDTH-1:0]     ext_imm_d,
    input  logic                      flush_e,
    output logic [IMM_WIDTH-1:0]      imm_src_d,
    output logic                      stall_fd,
    output logic                      valid_e,
    output logic [DATA_WIDTH-1:0]     imm_e,
    output logic [REG_ADDR_WIDTH-1:0] rd_e,
    output logic [REG_ADDR_WIDTH-1:0] rs1_e,
    output logic [REG_ADDR_WIDTH-1:0] rs2_e,
    output logic                      reg_write_e,
    output logic                      mem_read_e,
    output logic                      mem_write_e,
    output logic                      alu_src_e,
    output logic                      alu_a_pc_e,
    output logic [1:0]                result_src_e,
    output logic                      illegal_e,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Instruction fields
    logic [6:0]                opcode_d;
    logic [REG_ADDR_WIDTH-1:0] rd_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_d;

    assign opcode_d = instr_d[6:0];
    assign rd_d     = instr_d[7 +: REG_ADDR_WIDTH];
    assign rs1_d    = instr_d[15 +: REG_ADDR_WIDTH];
    assign rs2_d    = instr_d[20 +: REG_ADDR_WIDTH];

    // funct3/funct7 are consumed by the execute stage, not here.
    logic unused_funct;
    assign unused_funct = ^{instr_d[DATA_WIDTH-1:25], instr_d[14:12]};

    // Decoded controls for the D-stage instruction
    logic       reg_write_raw;
    logic       reg_write_d;
    logic       mem_read_d;
    logic       mem_write_d;
    logic       alu_src_d;
    logic       alu_a_pc_d;
    logic [1:0] result_src_d;
    logic       illegal_d;
    logic       uses_rs1_d;
    logic       uses_rs2_d;

    always_comb begin
        imm_src_d     = '0;
        reg_write_raw = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        alu_src_d     = 1'b0;
        alu_a_pc_d    = 1'b0;
        result_src_d  = RES_ALU;
        illegal_d     = 1'b0;
        uses_rs1_d    = 1'b0;
        uses_rs2_d    = 1'b0;
        case (opcode_d)
            OP_R: begin
                reg_write_raw = 1'b1;
                uses_rs1_d    = 1'b1;
                uses_rs2_d    = 1'b1;
            end
            OP_IMM: begin
                reg_write_raw = 1'b1;
                alu_src_d     = 1'b1;
                uses_rs1_d    = 1'b1;
            end
            OP_LOAD: begin
                reg_write_raw = 1'b1;
                alu_src_d     = 1'b1;
                mem_read_d    = 1'b1;
                result_src_d  = RES_MEM;
                uses_rs1_d    = 1'b1;
            end
            OP_JALR: begin
                reg_write_raw = 1'b1;
                alu_src_d     = 1'b1;
                result_src_d  = RES_PC4;
                uses_rs1_d    = 1'b1;
            end
            OP_STORE: begin
                imm_src_d   = IMM_WIDTH'(3'b001);
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
                uses_rs1_d  = 1'b1;
                uses_rs2_d  = 1'b1;
            end
            OP_BRANCH: begin
                imm_src_d  = IMM_WIDTH'(3'b010);
                uses_rs1_d = 1'b1;
                uses_rs2_d = 1'b1;
            end
            OP_JAL: begin
                imm_src_d     = IMM_WIDTH'(3'b011);
                reg_write_raw = 1'b1;
                result_src_d  = RES_PC4;
            end
            OP_LUI: begin
                imm_src_d     = IMM_WIDTH'(3'b100);
                reg_write_raw = 1'b1;
                result_src_d  = RES_IMM;
            end
            OP_AUIPC: begin
                imm_src_d     = IMM_WIDTH'(3'b100);
                reg_write_raw = 1'b1;
                alu_src_d     = 1'b1;
                alu_a_pc_d    = 1'b1;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // Writes to x0 are dropped at decode so later stages never see them.
    assign reg_write_d = reg_write_raw & (rd_d != '0);

    // D/E pipeline register state
    logic                      valid_e_q,     valid_e_d;
    logic [DATA_WIDTH-1:0]     imm_e_q,       imm_e_d;
    logic [REG_ADDR_WIDTH-1:0] rd_e_q,        rd_e_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_e_q,       rs1_e_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_e_q,       rs2_e_d;
    logic                      reg_write_e_q, reg_write_e_d;
    logic                      mem_read_e_q,  mem_read_e_d;
    logic                      mem_write_e_q, mem_write_e_d;
    logic                      alu_src_e_q,   alu_src_e_d;
    logic                      alu_a_pc_e_q,  alu_a_pc_e_d;
    logic [1:0]                result_src_e_q, result_src_e_d;
    logic                      illegal_e_q,   illegal_e_d;
    logic [CNT_WIDTH-1:0]      stall_count_q, stall_count_d;

    // A load in E whose destination a valid D instruction reads: the data
    // is not available until after E, so D must wait one cycle.
    logic load_use;
    assign load_use = valid_e_q & mem_read_e_q & (rd_e_q != '0) & valid_d &
                      ((uses_rs1_d & (rs1_d == rd_e_q)) |
                       (uses_rs2_d & (rs2_d == rd_e_q)));

    // A flush kills the D instruction anyway, so there is nothing to hold.
    assign stall_fd = load_use & ~flush_e;

    logic bubble;
    assign bubble = flush_e | load_use | ~valid_d;

    always_comb begin
        valid_e_d      = 1'b0;
        imm_e_d        = '0;
        rd_e_d         = '0;
        rs1_e_d        = '0;
        rs2_e_d        = '0;
        reg_write_e_d  = 1'b0;
        mem_read_e_d   = 1'b0;
        mem_write_e_d  = 1'b0;
        alu_src_e_d    = 1'b0;
        alu_a_pc_e_d   = 1'b0;
        result_src_e_d = RES_ALU;
        illegal_e_d    = 1'b0;
        if (!bubble) begin
            valid_e_d      = 1'b1;
            imm_e_d        = ext_imm_d;
            rd_e_d         = rd_d;
            rs1_e_d        = rs1_d;
            rs2_e_d        = rs2_d;
            reg_write_e_d  = reg_write_d;
            mem_read_e_d   = mem_read_d;
            mem_write_e_d  = mem_write_d;
            alu_src_e_d    = alu_src_d;
            alu_a_pc_e_d   = alu_a_pc_d;
            result_src_e_d = result_src_d;
            illegal_e_d    = illegal_d;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_fd && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_q      <= 1'b0;
            imm_e_q        <= '0;
            rd_e_q         <= '0;
            rs1_e_q        <= '0;
            rs2_e_q        <= '0;
            reg_write_e_q  <= 1'b0;
            mem_read_e_q   <= 1'b0;
            mem_write_e_q  <= 1'b0;
            alu_src_e_q    <= 1'b0;
            alu_a_pc_e_q   <= 1'b0;
            result_src_e_q <= RES_ALU;
            illegal_e_q    <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            valid_e_q      <= valid_e_d;
            imm_e_q        <= imm_e_d;
            rd_e_q         <= rd_e_d;
            rs1_e_q        <= rs1_e_d;
            rs2_e_q        <= rs2_e_d;
            reg_write_e_q  <= reg_write_e_d;
            mem_read_e_q   <= mem_read_e_d;
            mem_write_e_q  <= mem_write_e_d;
            alu_src_e_q    <= alu_src_e_d;
            alu_a_pc_e_q   <= alu_a_pc_e_d;
            result_src_e_q <= result_src_e_d;
            illegal_e_q    <= illegal_e_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign valid_e      = valid_e_q;
    assign imm_e        = imm_e_q;
    assign rd_e         = rd_e_q;
    assign rs1_e        = rs1_e_q;
    assign rs2_e        = rs2_e_q;
    assign reg_write_e  = reg_write_e_q;
    assign mem_read_e   = mem_read_e_q;
    assign mem_write_e  = mem_write_e_q;
    assign alu_src_e    = alu_src_e_q;
    assign alu_a_pc_e   = alu_a_pc_e_q;
    assign result_src_e = result_src_e_q;
    assign illegal_e    = illegal_e_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d;
    logic [31:0] ext_imm_d;
    logic        flush_e;

    logic [2:0]  imm_src_d;
    logic        stall_fd;
    logic        valid_e;
    logic [31:0] imm_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic        reg_write_e, mem_read_e, mem_write_e, alu_src_e, alu_a_pc_e;
    logic [1:0]  result_src_e;
    logic        illegal_e;
    logic [15:0] stall_count;

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    logic [2:0]  s_imm_src_d;
    logic        s_stall_fd, s_valid_e;
    logic [31:0] s_imm_e;
    logic [4:0]  s_rd_e, s_rs1_e, s_rs2_e;
    logic        s_reg_write_e, s_mem_read_e, s_mem_write_e, s_alu_src_e, s_alu_a_pc_e;
    logic [1:0]  s_result_src_e;
    logic        s_illegal_e;
    logic [2:0]  s_stall_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    decode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .ext_imm_d(ext_imm_d), .flush_e(flush_e), .imm_src_d(imm_src_d),
        .stall_fd(stall_fd), .valid_e(valid_e), .imm_e(imm_e), .rd_e(rd_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .reg_write_e(reg_write_e),
        .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e),
        .result_src_e(result_src_e), .illegal_e(illegal_e),
        .stall_count(stall_count)
    );

    decode_ctrl #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .ext_imm_d(ext_imm_d), .flush_e(flush_e), .imm_src_d(s_imm_src_d),
        .stall_fd(s_stall_fd), .valid_e(s_valid_e), .imm_e(s_imm_e), .rd_e(s_rd_e),
        .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .reg_write_e(s_reg_write_e),
        .mem_read_e(s_mem_read_e), .mem_write_e(s_mem_write_e),
        .alu_src_e(s_alu_src_e), .alu_a_pc_e(s_alu_a_pc_e),
        .result_src_e(s_result_src_e), .illegal_e(s_illegal_e),
        .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present an instruction in D; inputs change 1ns after an active edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] imm, input logic vld, input logic fl);
        instr_d   = ins;
        ext_imm_d = imm;
        valid_d   = vld;
        flush_e   = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack of E controls {rw, mr, mw, alu_src, alu_a_pc, res[1:0], illegal}
    function automatic logic [31:0] ctl();
        return {24'd0, reg_write_e, mem_read_e, mem_write_e, alu_src_e,
                alu_a_pc_e, result_src_e, illegal_e};
    endfunction

    localparam logic [31:0] ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] SW    = 32'h0020_A423; // sw x2,8(x1)
    localparam logic [31:0] BEQ   = 32'h0020_8463; // beq x1,x2,8
    localparam logic [31:0] JAL   = 32'h0000_00EF; // jal x1,0
    localparam logic [31:0] LUI5  = 32'h1234_52B7; // lui x5,0x12345
    localparam logic [31:0] LW2   = 32'h0000_A103; // lw x2,0(x1)
    localparam logic [31:0] ADD   = 32'h0041_01B3; // add x3,x2,x4
    localparam logic [31:0] LW0   = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADDX0 = 32'h0040_01B3; // add x3,x0,x4
    localparam logic [31:0] LUI2  = 32'h0001_0137; // lui x2,0x10 (rs1 field = 2)
    localparam logic [31:0] ILL   = 32'h0000_007F;

    initial begin
        rst_n = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_valid_e", {31'd0, valid_e}, 32'd0);
        check("rst_ctl", ctl(), 32'd0);
        check("rst_count", {16'd0, stall_count}, 32'd0);
        rst_n = 1'b1;

        // Decode sweep
        drive(ADDI, 32'd5, 1'b1, 1'b0);
        check("addi_imm_src", {29'd0, imm_src_d}, 32'd0);
        tick();
        check("addi_valid", {31'd0, valid_e}, 32'd1);
        check("addi_rd", {27'd0, rd_e}, 32'd1);
        check("addi_imm", imm_e, 32'd5);
        check("addi_ctl", ctl(), 32'b1001_0000);

        drive(SW, 32'd8, 1'b1, 1'b0);
        check("sw_imm_src", {29'd0, imm_src_d}, 32'd1);
        tick();
        check("sw_ctl", ctl(), 32'b0011_0000);
        check("sw_rs", {22'd0, rs1_e, rs2_e}, {22'd0, 5'd1, 5'd2});
        check("sw_imm", imm_e, 32'd8);

        drive(BEQ, 32'd8, 1'b1, 1'b0);
        check("beq_imm_src", {29'd0, imm_src_d}, 32'd2);
        tick();
        check("beq_ctl", ctl(), 32'd0);
        check("beq_valid", {31'd0, valid_e}, 32'd1);

        drive(JAL, 32'd0, 1'b1, 1'b0);
        check("jal_imm_src", {29'd0, imm_src_d}, 32'd3);
        tick();
        check("jal_ctl", ctl(), 32'b1000_0100);
        check("jal_rd", {27'd0, rd_e}, 32'd1);

        drive(LUI5, 32'h1234_5000, 1'b1, 1'b0);
        check("lui_imm_src", {29'd0, imm_src_d}, 32'd4);
        tick();
        check("lui_ctl", ctl(), 32'b1000_0110);
        check("lui_imm", imm_e, 32'h1234_5000);

        // Load-use hazard
        drive(LW2, 32'd0, 1'b1, 1'b0);
        check("lw_nostall", {31'd0, stall_fd}, 32'd0);
        tick();
        check("lw_ctl", ctl(), 32'b1101_0010);
        drive(ADD, 32'd0, 1'b1, 1'b0);
        check("lu_stall", {31'd0, stall_fd}, 32'd1);
        tick();
        check("lu_bubble", {31'd0, valid_e}, 32'd0);
        check("lu_bubble_ctl", ctl(), 32'd0);
        check("lu_stall_once", {31'd0, stall_fd}, 32'd0);
        check("lu_count", {16'd0, stall_count}, 32'd1);
        tick();
        check("add_valid", {31'd0, valid_e}, 32'd1);
        check("add_regs", {17'd0, rd_e, rs1_e, rs2_e}, {17'd0, 5'd3, 5'd2, 5'd4});
        check("add_ctl", ctl(), 32'b1000_0000);

        // No false hazard: load to x0
        drive(LW0, 32'd0, 1'b1, 1'b0);
        tick();
        check("lw0_rw", {31'd0, reg_write_e}, 32'd0);
        drive(ADDX0, 32'd0, 1'b1, 1'b0);
        check("x0_nostall", {31'd0, stall_fd}, 32'd0);
        tick();

        // No false hazard: LUI reads no register
        drive(LW2, 32'd0, 1'b1, 1'b0);
        tick();
        drive(LUI2, 32'h0001_0000, 1'b1, 1'b0);
        check("lui_nostall", {31'd0, stall_fd}, 32'd0);
        tick();
        check("lui2_valid", {31'd0, valid_e}, 32'd1);

        // Flush beats load-use
        drive(LW2, 32'd0, 1'b1, 1'b0);
        tick();
        drive(ADD, 32'd0, 1'b1, 1'b1);
        check("flush_nostall", {31'd0, stall_fd}, 32'd0);
        tick();
        check("flush_valid", {31'd0, valid_e}, 32'd0);
        check("flush_count", {16'd0, stall_count}, 32'd1);

        // Illegal opcode
        drive(ILL, 32'd0, 1'b1, 1'b0);
        check("ill_imm_src", {29'd0, imm_src_d}, 32'd0);
        tick();
        check("ill_valid", {31'd0, valid_e}, 32'd1);
        check("ill_ctl", ctl(), 32'd1);

        // valid_d low gives a bubble
        drive(ADDI, 32'd5, 1'b0, 1'b0);
        tick();
        check("nvld_valid", {31'd0, valid_e}, 32'd0);

        // Reset in the middle of a stall
        drive(LW2, 32'd0, 1'b1, 1'b0);
        tick();
        drive(ADD, 32'd0, 1'b1, 1'b0);
        check("pre_rst_stall", {31'd0, stall_fd}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall_fd}, 32'd0);
        check("midrst_valid", {31'd0, valid_e}, 32'd0);
        check("midrst_ctl", ctl(), 32'd0);
        check("midrst_count", {16'd0, stall_count}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Saturation: nine stalls; narrow counter holds at 7
        for (int i = 0; i < 9; i++) begin
            drive(LW2, 32'd0, 1'b1, 1'b0);
            tick();
            drive(ADD, 32'd0, 1'b1, 1'b0);
            tick();
        end
        check("sat_wide", {16'd0, stall_count}, 32'd9);
        check("sat_narrow", {29'd0, s_stall_count}, 32'd7);
        drive(LW2, 32'd0, 1'b1, 1'b0);
        tick();
        drive(ADD, 32'd0, 1'b1, 1'b0);
        check("sat_stall_active", {31'd0, s_stall_fd}, 32'd1);
        tick();
        check("sat_narrow_hold", {29'd0, s_stall_count}, 32'd7);
        check("sat_wide_10", {16'd0, stall_count}, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
